// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronised, debounced PLL lock qualifier with staged
// release of NUM_DOMAINS active-low domain resets, software reset hold,
// sticky lock-loss flag and saturating lock-loss counter.
// Every output is a flop; the FSM decides, and the output stage registers
// the decision one edge later.
module reset_sequencer #(
  parameter int NUM_DOMAINS        = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 16,
  parameter int SW_HOLD_CYCLES     = 32,
  parameter int CNT_W              = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  input  logic                   clr_lock_lost,
  output logic [NUM_DOMAINS-1:0] rstn_out,
  output logic                   ready,
  output logic                   lock_lost,
  output logic [CNT_W-1:0]       lock_loss_count
);

  // One shared timer covers stabilisation, stage gaps and the software hold.
  localparam int TMAX_A = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int TMAX   = (TMAX_A > SW_HOLD_CYCLES) ? TMAX_A : SW_HOLD_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);
  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(SW_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILIZE = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SW_HOLD   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   loss_q, loss_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic [NUM_DOMAINS-1:0] mask;

  // Synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State, timer, stage index and the pending lock-loss event.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= WAIT_LOCK;
      timer_q <= '0;
      idx_q   <= '0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic: lock loss beats software reset beats normal progress.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    loss_d  = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          timer_d = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          // Debounce abort: not a lock loss, domains were never released.
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          state_d = RELEASE;
          timer_d = '0;
          idx_d   = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          idx_d   = '0;
          loss_d  = 1'b1;
        end else if (sw_reset_req) begin
          state_d = SW_HOLD;
          timer_d = '0;
          idx_d   = '0;
        end else if (idx_q == IDX_LAST) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          idx_d   = '0;
          loss_d  = 1'b1;
        end else if (sw_reset_req) begin
          state_d = SW_HOLD;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      SW_HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
          idx_d   = '0;
          loss_d  = 1'b1;
        end else if (timer_q == HOLD_LAST) begin
          timer_d = '0;
          // A still-asserted request simply restarts the hold window.
          if (!sw_reset_req) begin
            state_d = RELEASE;
            idx_d   = '0;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Domain release mask: in RELEASE, every domain up to the stage index is out.
  always_comb begin
    mask = '0;
    if (state_q == RUN) begin
      mask = '1;
    end else if (state_q == RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++) mask[k] = (k <= int'(idx_q));
    end
  end

  // Registered reset outputs and ready.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstn_out <= '0;
      ready    <= 1'b0;
    end else begin
      rstn_out <= mask;
      ready    <= (state_q == RUN);
    end
  end

  // Sticky flag and saturating counter, updated together with the output drop.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_lost       <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      if (loss_q)             lock_lost <= 1'b1;
      else if (clr_lock_lost) lock_lost <= 1'b0;
      if (loss_q && (lock_loss_count != {CNT_W{1'b1}}))
        lock_loss_count <= lock_loss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters.
// Edge numbering: edge 0 is the first edge sampling the changed pll_locked.
module tb_reset_sequencer;

  localparam int ND = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          pll_locked;
  logic          sw_reset_req;
  logic          clr_lock_lost;
  logic [ND-1:0] rstn_out;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] lock_loss_count;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .NUM_DOMAINS(4), .SYNC_STAGES(2), .LOCK_STABLE_CYCLES(8),
    .STAGE_GAP_CYCLES(4), .SW_HOLD_CYCLES(5), .CNT_W(2)
  ) dut (
    .clk(clk), .rstn(rstn), .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req), .clr_lock_lost(clr_lock_lost),
    .rstn_out(rstn_out), .ready(ready), .lock_lost(lock_lost),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clk = ~clk;

  // Expected release mask, rel = edges since rstn_out[0] rose (negative = before).
  function automatic logic [ND-1:0] rel_mask(int rel);
    logic [ND-1:0] m;
    m = '0;
    for (int k = 0; k < ND; k++) m[k] = (rel >= 4 * k);
    return m;
  endfunction

  task automatic tick(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0; pll_locked = 1'b0; sw_reset_req = 1'b0; clr_lock_lost = 1'b0;
    tick(3);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rstn_out !== 4'b0000 || ready !== 1'b0 || lock_lost !== 1'b0 || lock_loss_count !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got rstn_out=%b ready=%b lost=%b cnt=%0d exp 0000/0/0/0",
               rstn_out, ready, lock_lost, lock_loss_count);
    end
    tick(4);
    checks++;
    if (rstn_out !== 4'b0000 || ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got rstn_out=%b ready=%b exp 0000/0", rstn_out, ready);
    end
  endtask

  // Release offsets from the first lock edge: 11/15/19/23, ready at 24.
  task automatic test_cold_start();
    pll_locked = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      tick();
      checks++;
      if (rstn_out !== rel_mask(e - 11) || ready !== (e >= 24)) begin
        failures++;
        $display("FAIL cold_start e=%0d got rstn_out=%b ready=%b exp %b/%b",
                 e, rstn_out, ready, rel_mask(e - 11), (e >= 24));
      end
    end
    checks++;
    if (lock_lost !== 1'b0 || lock_loss_count !== 2'd0) begin
      failures++;
      $display("FAIL cold_flags got lost=%b cnt=%0d exp 0/0", lock_lost, lock_loss_count);
    end
  endtask

  // Lock high 5 edges, low 1, high again from edge 6: release restarts at 6+11.
  task automatic test_glitch();
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      pll_locked = (e != 5);
      tick();
      checks++;
      if (rstn_out !== rel_mask(e - 17) || ready !== (e >= 30)) begin
        failures++;
        $display("FAIL glitch e=%0d got rstn_out=%b ready=%b exp %b/%b",
                 e, rstn_out, ready, rel_mask(e - 17), (e >= 30));
      end
    end
    checks++;
    if (lock_loss_count !== 2'd0 || lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL glitch_cnt got cnt=%0d lost=%b exp 0/0", lock_loss_count, lock_lost);
    end
  endtask

  task automatic test_lock_loss();
    logic [CW-1:0] exp_cnt;
    for (int i = 1; i <= 4; i++) begin
      exp_cnt = (i > 3) ? 2'd3 : CW'(i);
      pll_locked = 1'b0;
      tick(3);  // edges 0..2
      checks++;
      if (rstn_out !== 4'b1111 || lock_lost !== (i > 1)) begin
        failures++;
        $display("FAIL loss_pre i=%0d got rstn_out=%b lost=%b exp 1111/%b", i, rstn_out, lock_lost, (i > 1));
      end
      tick();   // edge 3
      checks++;
      if (rstn_out !== 4'b0000 || ready !== 1'b0 || lock_lost !== 1'b1 || lock_loss_count !== exp_cnt) begin
        failures++;
        $display("FAIL loss_drop i=%0d got rstn_out=%b ready=%b lost=%b cnt=%0d exp 0000/0/1/%0d",
                 i, rstn_out, ready, lock_lost, lock_loss_count, exp_cnt);
      end
      pll_locked = 1'b1;
      tick(25);
      checks++;
      if (rstn_out !== 4'b1111 || ready !== 1'b1) begin
        failures++;
        $display("FAIL loss_relock i=%0d got rstn_out=%b ready=%b exp 1111/1", i, rstn_out, ready);
      end
    end
    clr_lock_lost = 1'b1;
    tick();
    clr_lock_lost = 1'b0;
    checks++;
    if (lock_lost !== 1'b0 || lock_loss_count !== 2'd3) begin
      failures++;
      $display("FAIL clr_flag got lost=%b cnt=%0d exp 0/3", lock_lost, lock_loss_count);
    end
  endtask

  // Request sampled at edges 0..hold_len-1; rstn_out[0] rises at edge rise.
  task automatic test_sw_reset(int hold_len, int rise);
    for (int e = 0; e <= rise + 13; e++) begin
      sw_reset_req = (e < hold_len);
      tick();
      checks++;
      if (e == 0) begin
        if (rstn_out !== 4'b1111 || ready !== 1'b1) begin
          failures++;
          $display("FAIL sw_reset h=%0d e=0 got rstn_out=%b ready=%b exp 1111/1", hold_len, rstn_out, ready);
        end
      end else if (rstn_out !== rel_mask(e - rise) || ready !== (e >= rise + 13)) begin
        failures++;
        $display("FAIL sw_reset h=%0d e=%0d got rstn_out=%b ready=%b exp %b/%b",
                 hold_len, e, rstn_out, ready, rel_mask(e - rise), (e >= rise + 13));
      end
    end
    sw_reset_req = 1'b0;
    checks++;
    if (lock_loss_count !== 2'd3 || lock_lost !== 1'b0) begin
      failures++;
      $display("FAIL sw_flags h=%0d got cnt=%0d lost=%b exp 3/0", hold_len, lock_loss_count, lock_lost);
    end
  endtask

  // Lock loss and sw request seen together, then flag set with clear pulse.
  task automatic test_simultaneous();
    do_reset();
    pll_locked = 1'b1;
    tick(25);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_pre got ready=%b exp 1", ready);
    end
    pll_locked = 1'b0;
    tick(2);
    sw_reset_req = 1'b1;
    tick();             // edge 2: lock loss and sw request both seen
    sw_reset_req = 1'b0;
    clr_lock_lost = 1'b1;
    tick();             // edge 3: flag set collides with clear
    clr_lock_lost = 1'b0;
    checks++;
    if (rstn_out !== 4'b0000 || ready !== 1'b0 || lock_lost !== 1'b1 || lock_loss_count !== 2'd1) begin
      failures++;
      $display("FAIL simul_drop got rstn_out=%b ready=%b lost=%b cnt=%0d exp 0000/0/1/1",
               rstn_out, ready, lock_lost, lock_loss_count);
    end
    // Relock sampled at edge 4: a WAIT_LOCK restart releases at 15, not earlier.
    pll_locked = 1'b1;
    for (int e = 4; e <= 15; e++) begin
      tick();
      checks++;
      if (rstn_out !== rel_mask(e - 15)) begin
        failures++;
        $display("FAIL simul_relock e=%0d got rstn_out=%b exp %b", e, rstn_out, rel_mask(e - 15));
      end
    end
  endtask

  // Continues from test_simultaneous: rstn_out[1] rises at edge 19.
  task automatic test_reset_mid();
    tick(4);
    checks++;
    if (rstn_out !== 4'b0011) begin
      failures++;
      $display("FAIL mid_pre got rstn_out=%b exp 0011", rstn_out);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (rstn_out !== 4'b0000 || ready !== 1'b0 || lock_lost !== 1'b0 || lock_loss_count !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got rstn_out=%b ready=%b lost=%b cnt=%0d exp 0000/0/0/0",
               rstn_out, ready, lock_lost, lock_loss_count);
    end
    tick(2);
    rstn = 1'b1;
    for (int e = 0; e <= 24; e++) begin
      tick();
      checks++;
      if (rstn_out !== rel_mask(e - 11) || ready !== (e >= 24)) begin
        failures++;
        $display("FAIL mid_restart e=%0d got rstn_out=%b ready=%b exp %b/%b",
                 e, rstn_out, ready, rel_mask(e - 11), (e >= 24));
      end
    end
  endtask

  initial begin
    rstn = 1'b0; pll_locked = 1'b0; sw_reset_req = 1'b0; clr_lock_lost = 1'b0;
    test_reset();
    test_cold_start();
    test_glitch();
    test_lock_loss();
    test_sw_reset(1, 6);
    test_sw_reset(12, 16);
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised clock-health and reset sequencer sitting at the top level between the PLL and the generic `system` hierarchy. It replaces the single `rstn & locked` gate with a synchronised, debounced lock qualifier and a staged release of N independent active-low domain resets. It adds a software reset request, a sticky lock-loss flag, a saturating lock-loss counter and a `ready` indication. All logic runs on the PLL output clock.

## Interface

Parameters:
- `NUM_DOMAINS`, 4: number of reset domains released in order, index 0 first; must be >= 1.
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchroniser; must be >= 2.
- `LOCK_STABLE_CYCLES`, 1024: cycles `locked_s` must stay high before release; must be >= 1.
- `STAGE_GAP_CYCLES`, 16: cycles between successive domain releases; must be >= 1.
- `SW_HOLD_CYCLES`, 32: minimum reset hold after a software request; must be >= 1.
- `CNT_W`, 8: width of the lock-loss counter.

Ports:
- `clk`, in, 1: system clock (PLL CLKOUT0); the block's only clock.
- `rstn`, in, 1: reset, synchronous and active-low.
- `pll_locked`, in, 1: raw PLL LOCKED signal, asynchronous to `clk`.
- `sw_reset_req`, in, 1: level request for a software reset of all domains.
- `clr_lock_lost`, in, 1: single-cycle clear of `lock_lost`.
- `rstn_out`, out, NUM_DOMAINS: per-domain active-low resets, registered.
- `ready`, out, 1: high when all domains are released and the PLL is qualified.
- `lock_lost`, out, 1: sticky flag, set on lock loss after qualification.
- `lock_loss_count`, out, CNT_W: saturating count of lock-loss events.

## Operation

- Synchroniser: `pll_locked` passes through SYNC_STAGES flops to give `locked_s`. All synchroniser flops reset to 0.
- States: WAIT_LOCK (reset state), STABILIZE, RELEASE, RUN, SW_HOLD.
- WAIT_LOCK: all `rstn_out` = 0, `ready` = 0. Moves to STABILIZE when `locked_s` = 1, with the timer cleared.
- STABILIZE: the timer increments each cycle.
  - `locked_s` = 0 returns to WAIT_LOCK. This is not counted as a lock loss.
  - Timer = LOCK_STABLE_CYCLES-1 moves to RELEASE.
- RELEASE: `rstn_out[0]` goes high on entry. `rstn_out[k]` goes high STAGE_GAP_CYCLES after `rstn_out[k-1]`. Released bits stay high. The cycle after `rstn_out[NUM_DOMAINS-1]` rises, the block enters RUN and `ready` = 1.
- RUN: all `rstn_out` = 1 and `ready` = 1.
- Lock loss is `locked_s` = 0 in RELEASE, RUN or SW_HOLD. On lock loss:
  - the next cycle has all `rstn_out` = 0 and `ready` = 0;
  - `lock_lost` is set;
  - `lock_loss_count` increments, saturating at 2^CNT_W-1;
  - the state goes to WAIT_LOCK.
- Software reset: `sw_reset_req` = 1 in RELEASE or RUN drives all `rstn_out` and `ready` to 0 the next cycle and enters SW_HOLD with the timer cleared.
- SW_HOLD:
  - The timer counts to SW_HOLD_CYCLES-1.
  - If `sw_reset_req` is still 1 at that point, the timer restarts.
  - Otherwise the block goes to RELEASE directly, with no re-stabilisation.
- `sw_reset_req` is ignored in WAIT_LOCK and STABILIZE, because domains are already held.
- Simultaneous events:
  - Lock loss and `sw_reset_req` together: lock loss wins (counted, goes to WAIT_LOCK).
  - Lock-loss set and `clr_lock_lost` together: set wins.
  - `clr_lock_lost` never affects `lock_loss_count`.
- Reset (`rstn` = 0, sampled on a clk edge): state = WAIT_LOCK, all timers and the stage index = 0, `rstn_out` = all 0, `ready` = 0, `lock_lost` = 0, `lock_loss_count` = 0. This applies mid-sequence too. There is no partial release across a reset.

## Timing

- All outputs are registered, with no combinational input-to-output paths.
- Release latency: let edge 0 be the first edge that samples `pll_locked` = 1. `rstn_out[0]` rises after edge SYNC_STAGES+1+LOCK_STABLE_CYCLES.
- `rstn_out[k]` rises k·STAGE_GAP_CYCLES edges after `rstn_out[0]`. `ready` rises 1 edge after `rstn_out[NUM_DOMAINS-1]`.
- Lock-loss latency: all `rstn_out` go low SYNC_STAGES+1 edges after the first edge sampling `pll_locked` = 0. `lock_lost` and the count update on that same edge.
- Software reset: `rstn_out` goes low 1 edge after `sw_reset_req` is sampled high. With the request deasserted, `rstn_out[0]` rises SW_HOLD_CYCLES+1 edges after the hold begins.
- Glitches on `locked_s` shorter than LOCK_STABLE_CYCLES during STABILIZE produce no output activity.

## Test plan

Test parameters: NUM_DOMAINS=4, SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4, SW_HOLD_CYCLES=5, CNT_W=2.

- Cold start: `rstn` low for 3 cycles, then high; `pll_locked` rises and is first sampled at edge 0 -> `rstn_out[0..3]` rise after edges 11, 15, 19 and 23, `ready` after edge 24; `lock_lost` = 0, count = 0.
- Lock glitch in STABILIZE: `pll_locked` high 5 cycles, low 1 cycle, then high -> `rstn_out` stays 0; the release timing restarts from the re-rise; count stays 0.
- Lock loss in RUN, repeated 4 times with full re-lock in between -> each time `rstn_out` = 0 three edges after the drop and `lock_lost` = 1; count goes 1, 2, 3, 3 (saturates). `clr_lock_lost` pulse -> flag 0, count stays 3.
- Software reset in RUN: 1-cycle `sw_reset_req` -> `rstn_out` = 0 next edge; `rstn_out[0]` rises 6 edges after the hold begins; staged 4-cycle gaps follow. Holding the request 12 cycles extends the hold accordingly.
- Simultaneous: lock loss with `sw_reset_req`, and a lock-loss set with `clr_lock_lost` -> block ends in WAIT_LOCK, count increments, `lock_lost` = 1.
- `rstn` asserted mid-RELEASE (after `rstn_out[1]` is released) -> the next edge gives all outputs 0 and state WAIT_LOCK; a full sequence follows once `rstn` deasserts.
